// File: rtl/test_block_checker_pkg.sv
// Shared definitions for the clock-tree test chain receive checker:
// FSM states, PRBS-7 polynomial constants and the history fill length.
package test_block_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEEK   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // x^7 + x^6 + 1: each bit is the XOR of the bits 6 and 7 positions earlier
   localparam int PRBS_ORDER = 7;
   localparam int PRBS_TAP_A = 6;
   localparam int PRBS_TAP_B = 7;
   localparam logic [PRBS_ORDER-1:0] PRBS_LOCKUP = 7'b0;

   // Words needed before the history holds only freshly received bits
   function automatic int fill_words(input int width);
      return (PRBS_ORDER + width - 1) / width;
   endfunction

endpackage

// File: rtl/test_prbs7_predict.sv
// Combinational PRBS-7 predictor unrolled across one word: flags every bit that
// disagrees with the prediction made from the received stream, and shifts the history.
module test_prbs7_predict
   import test_block_checker_pkg::*;
#(
   parameter int width_p = 2
) (
   input  logic [PRBS_ORDER-1:0] hist,
   input  logic [width_p-1:0]    data,
   output logic [width_p-1:0]    mismatch,
   output logic [PRBS_ORDER-1:0] hist_next
);

   // Chronological bit line: index 0 is the oldest history bit, top is the newest data bit.
   // hist[0] holds the most recent received bit.
   logic [PRBS_ORDER+width_p-1:0] chron;

   genvar gi;
   generate
      for (gi = 0; gi < PRBS_ORDER; gi++) begin : g_hist_in
         assign chron[PRBS_ORDER-1-gi] = hist[gi];
      end
      for (gi = 0; gi < width_p; gi++) begin : g_bit
         assign chron[PRBS_ORDER+gi] = data[gi];
         assign mismatch[gi] = data[gi]
                             ^ chron[PRBS_ORDER+gi-PRBS_TAP_A]
                             ^ chron[PRBS_ORDER+gi-PRBS_TAP_B];
      end
      for (gi = 0; gi < PRBS_ORDER; gi++) begin : g_hist_out
         assign hist_next[gi] = chron[PRBS_ORDER+width_p-1-gi];
      end
   endgenerate

endmodule

// File: rtl/test_block_checker.sv
// Self-synchronizing PRBS-7 receive checker: acquires lock on a clean run of words,
// drops it on a run of errored words, and counts errored words while locked.
module test_block_checker
   import test_block_checker_pkg::*;
#(
   parameter int width_p        = 2,
   parameter int lock_words_p   = 16,
   parameter int unlock_words_p = 4,
   parameter int cnt_width_p    = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   en_i,
   input  logic                   clear_i,
   input  logic [width_p-1:0]     data_i,
   output logic                   locked_o,
   output logic                   err_o,
   output logic [cnt_width_p-1:0] err_count_o
);

   localparam int FILL_WORDS = fill_words(width_p);
   localparam int FILL_W     = $clog2(FILL_WORDS + 1);
   localparam int RUN_W      = $clog2(lock_words_p + 1);
   localparam int BAD_W      = $clog2(unlock_words_p + 1);

   state_t                  state_reg;
   logic [PRBS_ORDER-1:0]   hist_reg;
   logic [FILL_W-1:0]       fill_reg;
   logic [RUN_W-1:0]        run_reg;
   logic [BAD_W-1:0]        bad_reg;
   logic                    locked_reg;
   logic                    err_reg;
   logic [cnt_width_p-1:0]  count_reg;

   logic [PRBS_ORDER-1:0]   hist_next;
   logic [width_p-1:0]      mismatch;
   logic                    hist_valid;
   logic                    word_clean;

   test_prbs7_predict #(
      .width_p (width_p)
   ) u_predict (
      .hist      (hist_reg),
      .data      (data_i),
      .mismatch  (mismatch),
      .hist_next (hist_next)
   );

   assign hist_valid = (fill_reg == FILL_W'(FILL_WORDS));
   assign word_clean = hist_valid && (hist_reg != PRBS_LOCKUP) && (mismatch == '0);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_reg  <= ST_IDLE;
         hist_reg   <= PRBS_LOCKUP;
         fill_reg   <= '0;
         run_reg    <= '0;
         bad_reg    <= '0;
         locked_reg <= 1'b0;
         err_reg    <= 1'b0;
         count_reg  <= '0;
      end else begin
         err_reg <= 1'b0;
         if (en_i) begin
            hist_reg <= hist_next;
         end
         if (!en_i) begin
            state_reg  <= ST_IDLE;
            locked_reg <= 1'b0;
            fill_reg   <= '0;
            run_reg    <= '0;
            bad_reg    <= '0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  // The word sampled on the entering edge already counts toward the fill
                  state_reg <= ST_SEEK;
                  fill_reg  <= FILL_W'(1);
                  run_reg   <= '0;
               end
               ST_SEEK: begin
                  if (!hist_valid) begin
                     fill_reg <= fill_reg + FILL_W'(1);
                  end
                  if (!word_clean) begin
                     run_reg <= '0;
                  end else if (run_reg == RUN_W'(lock_words_p - 1)) begin
                     state_reg  <= ST_LOCKED;
                     locked_reg <= 1'b1;
                     run_reg    <= '0;
                     bad_reg    <= '0;
                  end else begin
                     run_reg <= run_reg + RUN_W'(1);
                  end
               end
               ST_LOCKED: begin
                  if (word_clean) begin
                     bad_reg <= '0;
                  end else begin
                     err_reg <= 1'b1;
                     if (!(&count_reg)) begin
                        count_reg <= count_reg + cnt_width_p'(1);
                     end
                     if (bad_reg == BAD_W'(unlock_words_p - 1)) begin
                        state_reg  <= ST_SEEK;
                        locked_reg <= 1'b0;
                        bad_reg    <= '0;
                        run_reg    <= '0;
                        fill_reg   <= FILL_W'(1);
                     end else begin
                        bad_reg <= bad_reg + BAD_W'(1);
                     end
                  end
               end
               default: begin
                  state_reg <= ST_IDLE;
               end
            endcase
         end
         // Clear wins over a same-cycle increment
         if (clear_i) begin
            count_reg <= '0;
         end
      end
   end

   assign locked_o    = locked_reg;
   assign err_o       = err_reg;
   assign err_count_o = count_reg;

endmodule

// File: tb/tb_test_block_checker.sv
// Randomized bench for test_block_checker against a bit-stream reference model.
module tb_test_block_checker;

   localparam int W      = 2;
   localparam int LOCK   = 16;
   localparam int UNLOCK = 4;
   localparam int CW     = 3;
   localparam int FILL   = (7 + W - 1) / W;
   localparam int CMAX   = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          en = 1'b0;
   logic          clr = 1'b0;
   logic [W-1:0]  data = '0;
   logic          locked;
   logic          err;
   logic [CW-1:0] cnt;

   test_block_checker #(
      .width_p        (W),
      .lock_words_p   (LOCK),
      .unlock_words_p (UNLOCK),
      .cnt_width_p    (CW)
   ) dut (
      .clk_i       (clk),
      .reset_n_i   (reset_n),
      .en_i        (en),
      .clear_i     (clr),
      .data_i      (data),
      .locked_o    (locked),
      .err_o       (err),
      .err_count_o (cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference model: full received bit history since reset, mode 0/1/2 = idle/seek/locked
   bit rq[$];
   int m_mode, m_run, m_bad, m_cnt, m_word, m_entry;
   bit m_err, m_locked;

   function automatic bit rbit(input int k);
      return (k < 0) ? 1'b0 : rq[k];
   endfunction

   task automatic model_step(input bit rn, input bit en_v, input bit clr_v, input logic [W-1:0] d);
      bit mism, hz, clean;
      int n;
      m_err = 1'b0;
      if (!rn) begin
         rq.delete();
         m_mode = 0; m_run = 0; m_bad = 0; m_cnt = 0; m_word = 0; m_entry = 0;
         m_locked = 1'b0;
         return;
      end
      if (!en_v) begin
         m_mode = 0;
         m_locked = 1'b0;
      end else begin
         n = rq.size();
         hz = 1'b1;
         for (int k = n - 7; k < n; k++) if (rbit(k)) hz = 1'b0;
         mism = 1'b0;
         for (int i = 0; i < W; i++) begin
            n = rq.size();
            if ((rbit(n - 6) ^ rbit(n - 7)) != d[i]) mism = 1'b1;
            rq.push_back(d[i]);
         end
         clean = !mism && !hz && (m_mode != 0) && (m_word - m_entry >= FILL);
         case (m_mode)
            0: begin m_mode = 1; m_entry = m_word; m_run = 0; end
            1: begin
               if (clean) begin
                  m_run++;
                  if (m_run == LOCK) begin m_mode = 2; m_bad = 0; m_locked = 1'b1; end
               end else m_run = 0;
            end
            default: begin
               if (clean) m_bad = 0;
               else begin
                  m_err = 1'b1;
                  if (m_cnt < CMAX) m_cnt++;
                  m_bad++;
                  if (m_bad == UNLOCK) begin
                     m_mode = 1; m_entry = m_word; m_run = 0; m_locked = 1'b0;
                  end
               end
            end
         endcase
         m_word++;
      end
      if (clr_v) m_cnt = 0;
   endtask

   task automatic cycle(input bit rn, input bit en_v, input bit clr_v, input logic [W-1:0] d);
      reset_n = rn; en = en_v; clr = clr_v; data = d;
      @(posedge clk);
      model_step(rn, en_v, clr_v, d);
      #1;
      check("locked", {31'b0, locked}, {31'b0, m_locked});
      check("err", {31'b0, err}, {31'b0, m_err});
      check("count", 32'(cnt), 32'(m_cnt));
   endtask

   // Transmitter: PRBS-7 generator, g[0] newest bit
   logic [6:0] g;
   task automatic next_word(output logic [W-1:0] w);
      bit nb;
      for (int i = 0; i < W; i++) begin
         nb = g[5] ^ g[6];
         g = {g[5:0], nb};
         w[i] = nb;
      end
   endtask

   task automatic run_clean(input int n, output int rise);
      logic [W-1:0] w;
      rise = -1;
      for (int k = 1; k <= n; k++) begin
         next_word(w);
         cycle(1, 1, 0, w);
         if (locked === 1'b1 && rise < 0) rise = k;
      end
   endtask

   initial begin
      logic [W-1:0] w;
      int rise, pulses, lost, fpos, fell;

      g = 7'h01;
      repeat (3) cycle(0, 1, 0, '1);
      $display("reset: locked=%0d err=%0d count=%0d", locked, err, cnt);

      pulses = 0; rise = -1;
      for (int k = 1; k <= 300; k++) begin
         next_word(w);
         cycle(1, 1, 0, w);
         if (locked === 1'b1 && rise < 0) rise = k;
         if (err === 1'b1) pulses++;
      end
      check("s1_lock_edge", rise, 20);
      check("s1_err_pulses", pulses, 0);
      check("s1_count", 32'(cnt), 0);
      $display("clean lock: rise after word %0d, count=%0d", rise, cnt);

      pulses = 0; lost = 0; fpos = $urandom_range(2, 6);
      for (int k = 0; k < 20; k++) begin
         next_word(w);
         if (k == fpos) w[1] = ~w[1];
         cycle(1, 1, 0, w);
         if (err === 1'b1) pulses++;
         if (locked !== 1'b1) lost = 1;
      end
      check("s2_locked_kept", lost, 0);
      check("s2_pulses", pulses, 3);
      check("s2_count", 32'(cnt), 3);
      $display("single flip at word %0d: pulses=%0d count=%0d", fpos, pulses, cnt);

      next_word(w);
      cycle(1, 1, 1, w);
      check("s3_cleared", 32'(cnt), 0);
      fell = 0;
      for (int k = 1; k <= 10; k++) begin
         next_word(w);
         cycle(1, 1, 0, '0);
         if (locked === 1'b0 && fell == 0) fell = k;
      end
      check("s3_fell", fell > 0, 1);
      check("s3_count", 32'(cnt), 4);
      run_clean(40, rise);
      check("s3_relock", rise > 0, 1);
      $display("zero burst: fell at word %0d, count=%0d, relock at %0d", fell, cnt, rise);

      next_word(w);
      cycle(1, 0, 0, w);
      check("s4_en_drop", {31'b0, locked}, 0);
      run_clean(30, rise);
      check("s4_relock_edge", rise, 20);
      $display("en drop: relock after word %0d", rise);

      next_word(w);
      cycle(1, 1, 1, w);
      for (int inj = 0; inj < 10; inj++) begin
         for (int k = 0; k < 8; k++) begin
            next_word(w);
            if (k == 0) w[$urandom_range(0, W - 1)] ^= 1'b1;
            cycle(1, 1, 0, w);
         end
      end
      check("s5_sat", 32'(cnt), CMAX);
      next_word(w);
      w[0] = ~w[0];
      cycle(1, 1, 1, w);
      check("s5_clr_err", {31'b0, err}, 1);
      check("s5_clr_cnt", 32'(cnt), 0);
      $display("saturation: reached %0d, clear on errored word gives %0d", CMAX, cnt);
      run_clean(8, rise);

      next_word(w);
      cycle(1, 1, 1, w);
      for (int k = 0; k < 16; k++) begin
         next_word(w);
         if (k == 0) w[0] = ~w[0];
         if (k == 8) w[1] = ~w[1];
         cycle(1, 1, 0, w);
      end
      check("s6_count5", 32'(cnt), 5);
      next_word(w);
      cycle(0, 1, 0, w);
      check("s6_rst_locked", {31'b0, locked}, 0);
      check("s6_rst_count", 32'(cnt), 0);
      run_clean(30, rise);
      check("s6_relock_edge", rise, 20);
      $display("reset pulse while locked: relock after word %0d", rise);

      repeat (2) cycle(0, 1, 0, '0);
      lost = 0;
      for (int k = 0; k < 60; k++) begin
         cycle(1, 1, 0, '0);
         if (locked !== 1'b0) lost = 1;
      end
      check("s7_never_lock", lost, 0);
      check("s7_count", 32'(cnt), 0);
      $display("all-zero stream: ever locked=%0d count=%0d", lost, cnt);

      g = 7'($urandom_range(1, 127));
      repeat (2) cycle(0, 1, 0, '0);
      for (int k = 0; k < 600; k++) begin
         next_word(w);
         if ($urandom_range(0, 15) == 0) w[$urandom_range(0, W - 1)] ^= 1'b1;
         cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 49) != 0),
               ($urandom_range(0, 39) == 0), w);
      end
      $display("random phase: 600 words done, count=%0d", cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
